// File: rtl/kgp_io_pkg.sv
// Shared definitions for the KGP_RISC board I/O handshake blocks.
package kgp_io_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    VALID    = 2'd2,
    WAIT_REL = 2'd3
  } io_state_t;

  localparam int unsigned KGP_DATA_W          = 5;
  localparam int unsigned KGP_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/kgp_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer with edge pulses.
module kgp_debounce
  import kgp_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KGP_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press,
  output logic rel
);

  logic       sync1;
  logic       sync2;
  logic       level_d;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      level_d <= level;
      // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
      if (sync2 != level) begin
        if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_d;
  assign rel   = ~level & level_d;

endmodule

// File: rtl/kgp_switch_input_port.sv
// Board switch-input responder: debounced button press captures the switch bank.
module kgp_switch_input_port
  import kgp_io_pkg::*;
#(
  parameter int unsigned DATA_W          = KGP_DATA_W,
  parameter int unsigned OUT_W           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = KGP_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              button,
  input  logic [DATA_W-1:0] array,
  input  logic              ack,
  output logic [OUT_W-1:0]  data_out,
  output logic              valid,
  output logic              busy,
  output logic [7:0]        capture_cnt
);

  io_state_t         state_q;
  io_state_t         state_d;
  logic [DATA_W-1:0] arr_s1;
  logic [DATA_W-1:0] arr_s2;
  logic              btn_level;
  logic              btn_press;
  logic              btn_rel;
  logic              capture;

  kgp_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .din  (button),
    .level(btn_level),
    .press(btn_press),
    .rel  (btn_rel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arr_s1 <= '0;
      arr_s2 <= '0;
    end else begin
      arr_s1 <= array;
      arr_s2 <= arr_s1;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) state_d = ARMED;
      end
      ARMED: begin
        if (!req) begin
          state_d = IDLE;
        end else if (btn_press) begin
          capture = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (ack) state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!btn_level || btn_rel) state_d = req ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      data_out    <= '0;
      capture_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        data_out    <= OUT_W'(arr_s2);
        capture_cnt <= capture_cnt + 8'd1;
      end
    end
  end

  assign valid = (state_q == VALID);
  assign busy  = (state_q != IDLE);

endmodule
